// File: rtl/ct_pt_loader_pkg.sv
// Shared word and ciphertext/plaintext buffer types for the ct_pt_loader slice.
// ct_pt_loader instances must use N/W equal to N_SLOTS_L/W_BITS_L so ports match CT_t/PT_t.
package ct_pt_loader_pkg;

  localparam int N_SLOTS_L = 4;
  localparam int W_BITS_L  = 8;
  localparam int Q_MOD_L   = 97;

  typedef logic [W_BITS_L-1:0] word_t;

  typedef struct packed {
    word_t [N_SLOTS_L-1:0] b;
    word_t [N_SLOTS_L-1:0] a;
  } CT_t;

  typedef word_t [N_SLOTS_L-1:0] PT_t;

  // Slot counter width, kept at least one bit so N=1 still has a legal index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ct_pt_loader_range_red.sv
// coeff_range_red: maps a coefficient in [0, 2*QP) into [0, QP) and flags the wrap.
// Only compiled when CT_LOADER_RANGE_CHECK_EN is defined, matching its sole instantiation.
`ifdef CT_LOADER_RANGE_CHECK_EN
module coeff_range_red #(
  parameter int W  = 8,
  parameter int QP = 97
) (
  input  logic [W-1:0] coeff_i,
  output logic [W-1:0] coeff_o,
  output logic         over_o
);

  localparam logic [W-1:0] QP_W = W'(QP);

  always_comb begin
    over_o  = (coeff_i >= QP_W);
    coeff_o = over_o ? (coeff_i - QP_W) : coeff_i;
  end

endmodule
`endif

// File: rtl/ct_pt_loader.sv
// Streaming loader: collects A, B and Gamma coefficients into registered CT/PT buffers.
// Define CT_LOADER_RANGE_CHECK_EN to reduce and flag A/B coefficients that are >= QP.
module ct_pt_loader
  import ct_pt_loader_pkg::*;
#(
  parameter int N  = N_SLOTS_L,
  parameter int W  = W_BITS_L,
  parameter int QP = Q_MOD_L
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_coeff,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output CT_t          out_ct,
  output PT_t          out_gamma,
  output logic         frame_err,
  output logic         range_err
);

  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_LOAD_G,
    S_FULL
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          frameErr_q, frameErr_d;
  logic          rangeErr_q, rangeErr_d;
  CT_t           ctBuf_q;
  PT_t           gammaBuf_q;

  logic          accept;
  logic          lastSlot;
  logic          finalBeat;
  logic [W-1:0]  redCoeff;
  logic          redOver;

`ifdef CT_LOADER_RANGE_CHECK_EN
  coeff_range_red #(
    .W  (W),
    .QP (QP)
  ) u_range_red (
    .coeff_i (in_coeff),
    .coeff_o (redCoeff),
    .over_o  (redOver)
  );
`else
  logic [31:0] unused_qp;
  assign unused_qp = 32'(QP);
  assign redCoeff  = in_coeff;
  assign redOver   = 1'b0;
`endif

  assign in_ready  = !reset && (state_q != S_FULL);
  assign out_valid = (state_q == S_FULL);
  assign accept    = in_valid && in_ready;
  assign lastSlot  = (idx_q == IDX_LAST);
  assign finalBeat = (state_q == S_LOAD_G) && lastSlot;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    frameErr_d = frameErr_q;
    rangeErr_d = rangeErr_q;
    case (state_q)
      S_FULL: begin
        if (out_ready) begin
          state_d = S_LOAD_A;
          idx_d   = '0;
        end
      end
      default: begin
        if (accept) begin
          if ((state_q != S_LOAD_G) && redOver) begin
            rangeErr_d = 1'b1;
          end
          // An early last abandons the frame; a missing last still lets it complete.
          if (in_last && !finalBeat) begin
            state_d    = S_LOAD_A;
            idx_d      = '0;
            frameErr_d = 1'b1;
          end else begin
            if (finalBeat && !in_last) begin
              frameErr_d = 1'b1;
            end
            if (lastSlot) begin
              idx_d = '0;
              case (state_q)
                S_LOAD_A: state_d = S_LOAD_B;
                S_LOAD_B: state_d = S_LOAD_G;
                default:  state_d = S_FULL;
              endcase
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_LOAD_A;
      idx_q      <= '0;
      frameErr_q <= 1'b0;
      rangeErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      frameErr_q <= frameErr_d;
      rangeErr_q <= rangeErr_d;
    end
  end

  // Buffers only move on accepted beats, which keeps them frozen while S_FULL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctBuf_q    <= '0;
      gammaBuf_q <= '0;
    end else if (accept) begin
      case (state_q)
        S_LOAD_A: ctBuf_q.a[idx_q]  <= word_t'(redCoeff);
        S_LOAD_B: ctBuf_q.b[idx_q]  <= word_t'(redCoeff);
        S_LOAD_G: gammaBuf_q[idx_q] <= word_t'(in_coeff);
        default: ;
      endcase
    end
  end

  assign out_ct    = ctBuf_q;
  assign out_gamma = gammaBuf_q;
  assign frame_err = frameErr_q;
  assign range_err = rangeErr_q;

endmodule
